// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel deserializer with one-word valid/ready holding register
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_valid, s_bit, s_start serial input; s_start marks the first bit of a word
//   s_ready                 serial bit accepted this cycle
//   p_valid, p_data         holding register occupancy and assembled word
//   p_ready                 downstream takes the word this cycle
//   frame_err, ovr_err      sticky error flags, cleared by clr_err
module sipo_deser #(
  parameter int WIDTH = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_bit,
  input  logic             s_start,
  output logic             s_ready,
  output logic             p_valid,
  output logic [WIDTH-1:0] p_data,
  input  logic             p_ready,
  output logic             frame_err,
  output logic             ovr_err,
  input  logic             clr_err
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {EMPTY, FULL} st_t;
  st_t st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] shift, shift_nx, hold, shifted, started;
  logic last, acc, done;
  assign last = cnt == CW'(WIDTH-1);
  // only the completing bit can stall, and only while the held word is not being taken
  assign s_ready = !(p_valid && !p_ready && last);
  assign acc = s_valid && s_ready;
  assign done = acc && !s_start && last;
  assign p_valid = st == FULL;
  assign p_data = hold;
  assign shifted = MSB_FIRST ? {shift[WIDTH-2:0], s_bit} : {s_bit, shift[WIDTH-1:1]};
  // s_start discards the partial word and makes s_bit the first bit of a fresh one
  assign started = MSB_FIRST ? {{(WIDTH-1){1'b0}}, s_bit} : {s_bit, {(WIDTH-1){1'b0}}};
  always_comb begin
    shift_nx = !acc ? shift : s_start ? started : shifted;
    cnt_nx = !acc ? cnt : s_start ? CW'(1) : last ? '0 : cnt + CW'(1);
    st_nx = done ? FULL : p_ready ? EMPTY : st;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= EMPTY;
      cnt <= '0;
      shift <= '0;
      hold <= '0;
      frame_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
      shift <= shift_nx;
      hold <= done ? shift_nx : hold;
      frame_err <= (acc && s_start && cnt != '0) || (frame_err && !clr_err);
      ovr_err <= (s_valid && !s_ready) || (ovr_err && !clr_err);
    end
  end
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed self-checking bench for sipo_deser (MSB-first and LSB-first instances)
module tb_sipo_deser;
  logic clk = 0, rst_n = 0, s_valid = 0, s_bit = 0, s_start = 0, p_ready = 0, clr_err = 0;
  logic s_ready, p_valid, frame_err, ovr_err;
  logic [3:0] p_data;
  logic l_ready, l_valid, l_ferr, l_oerr;
  logic [3:0] l_data;
  int cmp = 0, bad = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_bit(s_bit), .s_start(s_start),
    .s_ready(s_ready), .p_valid(p_valid), .p_data(p_data), .p_ready(p_ready),
    .frame_err(frame_err), .ovr_err(ovr_err), .clr_err(clr_err));

  sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_bit(s_bit), .s_start(s_start),
    .s_ready(l_ready), .p_valid(l_valid), .p_data(l_data), .p_ready(p_ready),
    .frame_err(l_ferr), .ovr_err(l_oerr), .clr_err(clr_err));

  task automatic drv(input logic v, input logic b, input logic st);
    @(negedge clk);
    s_valid = v;
    s_bit = b;
    s_start = st;
    #1;
  endtask

  task automatic test_reset;
    #12 rst_n = 1;
    cmp++; if (p_valid !== 1'b0) begin bad++; $display("FAIL reset_p_valid: got %b want 0", p_valid); end
    cmp++; if (p_data !== 4'b0000) begin bad++; $display("FAIL reset_p_data: got %b want 0000", p_data); end
    cmp++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    p_ready = 0;
    drv(1, 1, 0); drv(1, 1, 0); drv(1, 1, 0); drv(1, 1, 0);
    drv(1, 1, 0);
    drv(1, 0, 1);
    drv(0, 0, 0);
    cmp++; if (frame_err !== 1'b1 || p_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_state: got ferr=%b pv=%b want 1 1", frame_err, p_valid); end
    #2 rst_n = 0;
    #1;
    cmp++; if (p_valid !== 1'b0 || p_data !== 4'b0000) begin bad++; $display("FAIL async_reset_out: got pv=%b pd=%b want 0 0000", p_valid, p_data); end
    cmp++; if (frame_err !== 1'b0 || ovr_err !== 1'b0) begin bad++; $display("FAIL async_reset_err: got f=%b o=%b want 0 0", frame_err, ovr_err); end
    #1 rst_n = 1;
    cmp++; if (s_ready !== 1'b1) begin bad++; $display("FAIL release_s_ready: got %b want 1", s_ready); end
    p_ready = 1;
    drv(1, 0, 0); drv(1, 0, 0); drv(1, 1, 0); drv(1, 1, 0);
    drv(0, 0, 0);
    cmp++; if (p_valid !== 1'b1 || p_data !== 4'b0011) begin bad++; $display("FAIL post_reset_word: got pv=%b pd=%b want 1 0011", p_valid, p_data); end
    drv(0, 0, 0);
  endtask

  task automatic test_basic;
    p_ready = 1;
    drv(1, 1, 0); drv(1, 0, 0); drv(1, 1, 0);
    drv(1, 1, 0);
    cmp++; if (p_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got pv=%b want 0", p_valid); end
    drv(0, 0, 0);
    cmp++; if (p_valid !== 1'b1 || p_data !== 4'b1011) begin bad++; $display("FAIL basic_msb: got pv=%b pd=%b want 1 1011", p_valid, p_data); end
    cmp++; if (l_valid !== 1'b1 || l_data !== 4'b1101) begin bad++; $display("FAIL basic_lsb: got pv=%b pd=%b want 1 1101", l_valid, l_data); end
    drv(0, 0, 0);
    cmp++; if (p_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle: got pv=%b want 0", p_valid); end
  endtask

  task automatic test_backpressure;
    p_ready = 0;
    drv(1, 1, 0); drv(1, 1, 0); drv(1, 0, 0); drv(1, 0, 0);
    drv(1, 0, 0); drv(1, 1, 0); drv(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 0);
      cmp++; if (s_ready !== 1'b0 || p_data !== 4'b1100) begin bad++; $display("FAIL bp_stall%0d: got sr=%b pd=%b want 0 1100", i, s_ready, p_data); end
    end
    @(negedge clk);
    p_ready = 1;
    #1;
    cmp++; if (s_ready !== 1'b1 || p_data !== 4'b1100) begin bad++; $display("FAIL bp_release: got sr=%b pd=%b want 1 1100", s_ready, p_data); end
    cmp++; if (ovr_err !== 1'b1) begin bad++; $display("FAIL bp_ovr: got %b want 1", ovr_err); end
    @(negedge clk);
    s_valid = 0;
    p_ready = 0;
    clr_err = 1;
    #1;
    cmp++; if (p_valid !== 1'b1 || p_data !== 4'b0111) begin bad++; $display("FAIL bp_next: got pv=%b pd=%b want 1 0111", p_valid, p_data); end
    @(negedge clk);
    clr_err = 0;
    p_ready = 1;
    #1;
    cmp++; if (ovr_err !== 1'b0) begin bad++; $display("FAIL bp_ovr_clr: got %b want 0", ovr_err); end
    drv(0, 0, 0);
  endtask

  task automatic test_back_to_back;
    p_ready = 0;
    drv(1, 1, 0); drv(1, 0, 0); drv(1, 1, 0); drv(1, 0, 0);
    drv(1, 0, 0); drv(1, 1, 0); drv(1, 0, 0);
    cmp++; if (p_data !== 4'b1010 || p_valid !== 1'b1) begin bad++; $display("FAIL b2b_hold: got pv=%b pd=%b want 1 1010", p_valid, p_data); end
    @(negedge clk);
    s_bit = 1;
    p_ready = 1;
    #1;
    cmp++; if (s_ready !== 1'b1) begin bad++; $display("FAIL b2b_s_ready: got %b want 1", s_ready); end
    @(negedge clk);
    s_valid = 0;
    p_ready = 0;
    #1;
    cmp++; if (p_valid !== 1'b1 || p_data !== 4'b0101) begin bad++; $display("FAIL b2b_new: got pv=%b pd=%b want 1 0101", p_valid, p_data); end
    p_ready = 1;
    drv(0, 0, 0);
    drv(0, 0, 0);
    cmp++; if (p_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got pv=%b want 0", p_valid); end
  endtask

  task automatic test_framing;
    p_ready = 1;
    drv(1, 1, 1);
    drv(1, 1, 0);
    cmp++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_start_at_0: got %b want 0", frame_err); end
    drv(1, 0, 1);
    drv(1, 1, 0);
    cmp++; if (frame_err !== 1'b1) begin bad++; $display("FAIL frame_set: got %b want 1", frame_err); end
    drv(1, 1, 0); drv(1, 0, 0);
    drv(0, 0, 0);
    cmp++; if (p_valid !== 1'b1 || p_data !== 4'b0110) begin bad++; $display("FAIL frame_word: got pv=%b pd=%b want 1 0110", p_valid, p_data); end
    clr_err = 1;
    drv(0, 0, 0);
    clr_err = 0;
    cmp++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_clr: got %b want 0", frame_err); end
  endtask

  task automatic test_overrun;
    p_ready = 0;
    drv(1, 1, 0); drv(1, 0, 0); drv(1, 0, 0); drv(1, 1, 0);
    drv(1, 1, 0); drv(1, 1, 0); drv(1, 1, 0);
    drv(1, 1, 0);
    cmp++; if (s_ready !== 1'b0) begin bad++; $display("FAIL ovr_stall: got %b want 0", s_ready); end
    drv(0, 0, 0);
    cmp++; if (ovr_err !== 1'b1 || p_data !== 4'b1001) begin bad++; $display("FAIL ovr_set: got o=%b pd=%b want 1 1001", ovr_err, p_data); end
    p_ready = 1;
    drv(0, 0, 0);
    cmp++; if (p_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain: got pv=%b want 0", p_valid); end
    drv(1, 0, 0);
    drv(0, 0, 0);
    cmp++; if (p_valid !== 1'b1 || p_data !== 4'b1110) begin bad++; $display("FAIL ovr_cnt_kept: got pv=%b pd=%b want 1 1110", p_valid, p_data); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_framing;
    test_overrun;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
